// File: rtl/preadder_sched.sv
// preadder_sched: round-robin issue scheduler for the 4-thread interleaved BN254 preadder
// Ports: clk/rst (sync, active-high); req_valid/req_mode1/req_mode2/req_ready per-thread handshake;
//   stall blocks issue; pa_sel_valid/pa_thread select operands now, pa_mode1/pa_mode2 lag LAT_MODE;
//   out_valid/out_thread tag the result LAT_OUT after issue; busy = any tag in flight;
//   err_unprimed sticky flag, live only when PREADDER_SCHED_PRIME_CHECK_EN is defined.
module preadder_sched #(
  parameter int LAT_MODE = 1,
  parameter int LAT_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req_valid,
  input  logic [3:0][1:0] req_mode1,
  input  logic [3:0][1:0] req_mode2,
  output logic [3:0]      req_ready,
  input  logic            stall,
  output logic            pa_sel_valid,
  output logic [1:0]      pa_thread,
  output logic [1:0]      pa_mode1,
  output logic [1:0]      pa_mode2,
  output logic            out_valid,
  output logic [1:0]      out_thread,
  output logic            err_unprimed,
  output logic            busy
);
  logic [1:0] ptr, gid, thr_q, m1_in, m2_in;
  logic issue;
  logic [LAT_MODE-1:0][1:0] m1_q, m2_q;
  logic [LAT_OUT-1:0] v_q;
  logic [LAT_OUT-1:0][1:0] t_q;
  // scan from farthest to nearest so the first valid at/after ptr wins
  always_comb begin
    gid = '0;
    issue = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (!stall && req_valid[ptr + 2'(k)]) begin
        issue = 1'b1;
        gid = ptr + 2'(k);
      end
  end
  assign req_ready = issue ? 4'b0001 << gid : 4'b0000;
  assign pa_sel_valid = issue;
  assign pa_thread = issue ? gid : thr_q;
`ifdef PREADDER_SCHED_PRIME_CHECK_EN
  logic [3:0] primed;
  logic unprimed, acc_req;
  assign unprimed = issue && !primed[gid];
  assign acc_req = req_mode1[gid] == 2'b01 || req_mode2[gid] == 2'b01;
  assign m1_in = !issue ? 2'b00 : (unprimed && req_mode1[gid] == 2'b01) ? 2'b00 : req_mode1[gid];
  assign m2_in = !issue ? 2'b00 : (unprimed && req_mode2[gid] == 2'b01) ? 2'b00 : req_mode2[gid];
  // an idle cycle still writes the held thread's delay slot with junk
  always_ff @(posedge clk) begin
    if (rst) begin
      primed <= '0;
      err_unprimed <= 1'b0;
    end else begin
      if (issue) primed[gid] <= 1'b1;
      else primed[thr_q] <= 1'b0;
      if (unprimed && acc_req) err_unprimed <= 1'b1;
    end
  end
`else
  assign m1_in = issue ? req_mode1[gid] : 2'b00;
  assign m2_in = issue ? req_mode2[gid] : 2'b00;
  assign err_unprimed = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      thr_q <= '0;
      m1_q <= '0;
      m2_q <= '0;
      v_q <= '0;
      t_q <= '0;
    end else begin
      if (issue) begin
        ptr <= gid + 2'd1;
        thr_q <= gid;
      end
      m1_q[0] <= m1_in;
      m2_q[0] <= m2_in;
      for (int k = 1; k < LAT_MODE; k++) begin
        m1_q[k] <= m1_q[k-1];
        m2_q[k] <= m2_q[k-1];
      end
      v_q[0] <= issue;
      t_q[0] <= gid;
      for (int k = 1; k < LAT_OUT; k++) begin
        v_q[k] <= v_q[k-1];
        t_q[k] <= t_q[k-1];
      end
    end
  end
  assign pa_mode1 = m1_q[LAT_MODE-1];
  assign pa_mode2 = m2_q[LAT_MODE-1];
  assign out_valid = v_q[LAT_OUT-1];
  assign out_thread = t_q[LAT_OUT-1];
  assign busy = |v_q;
endmodule

// File: tb/tb_preadder_sched.sv
// tb_preadder_sched: directed vectors with a queued scoreboard on out_thread
module tb_preadder_sched;
  logic clk = 1'b0;
  logic rst, stall, pa_sel_valid, out_valid, err_unprimed, busy;
  logic [3:0] req_valid, req_ready;
  logic [3:0][1:0] req_mode1, req_mode2;
  logic [1:0] pa_thread, pa_mode1, pa_mode2, out_thread;
  int total = 0, bad = 0;
  logic [1:0] exp_q[$];
`ifdef PREADDER_SCHED_PRIME_CHECK_EN
  localparam int PC = 1;
`else
  localparam int PC = 0;
`endif
  always #5 clk = ~clk;
  preadder_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode1(req_mode1), .req_mode2(req_mode2),
    .req_ready(req_ready), .stall(stall), .pa_sel_valid(pa_sel_valid), .pa_thread(pa_thread),
    .pa_mode1(pa_mode1), .pa_mode2(pa_mode2), .out_valid(out_valid), .out_thread(out_thread),
    .err_unprimed(err_unprimed), .busy(busy)
  );
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] v, input logic [1:0] m1, input logic [1:0] m2, input logic s);
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      req_mode1[i] = m1;
      req_mode2[i] = m2;
    end
    stall = s;
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(4'b0000, 2'b00, 2'b00, 1'b0);
      chk("idle_sel", {7'd0, pa_sel_valid}, 8'd0);
      tick;
    end
  endtask
  task automatic pulse_rst;
    rst = 1'b1;
    drive(4'b0000, 2'b00, 2'b00, 1'b0);
    tick;
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_thread_unexpected: got %0d want none", out_thread);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (out_thread !== e) begin
          bad++;
          $display("FAIL out_thread: got %0d want %0d", out_thread, e);
        end
      end
    end
  end
  initial begin
    logic [3:0] v2[5];
    int g2[5];
    v2 = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000};
    g2 = '{1, 3, 1, 3, 3};
    rst = 1'b1;
    drive(4'b0000, 2'b00, 2'b00, 1'b0);
    tick;
    tick;
    chk("rst_sel", {7'd0, pa_sel_valid}, 8'd0);
    chk("rst_thread", {6'd0, pa_thread}, 8'd0);
    chk("rst_mode1", {6'd0, pa_mode1}, 8'd0);
    chk("rst_mode2", {6'd0, pa_mode2}, 8'd0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_out_thread", {6'd0, out_thread}, 8'd0);
    chk("rst_err", {7'd0, err_unprimed}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ready", {4'd0, req_ready}, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 2'b10, 2'b10, 1'b0);
      chk("rr_ready", {4'd0, req_ready}, 8'(1 << (i % 4)));
      chk("rr_thread", {6'd0, pa_thread}, 8'(i % 4));
      chk("rr_sel", {7'd0, pa_sel_valid}, 8'd1);
      if (i > 0) chk("rr_mode1", {6'd0, pa_mode1}, 8'd2);
      if (i > 0) chk("rr_busy", {7'd0, busy}, 8'd1);
      exp_q.push_back(2'(i % 4));
      tick;
    end
    for (int i = 0; i < 5; i++) begin
      drive(v2[i], 2'b00, 2'b00, 1'b0);
      chk("pair_ready", {4'd0, req_ready}, 8'(1 << g2[i]));
      exp_q.push_back(2'(g2[i]));
      tick;
    end
    idle(3);
    pulse_rst;
    drive(4'b0100, 2'b01, 2'b00, 1'b0);
    chk("t2_ready", {4'd0, req_ready}, 8'd4);
    exp_q.push_back(2'd2);
    tick;
    drive(4'b0000, 2'b00, 2'b00, 1'b0);
    chk("t2_mode1", {6'd0, pa_mode1}, PC ? 8'd0 : 8'd1);
    chk("t2_mode2", {6'd0, pa_mode2}, 8'd0);
    chk("t2_err", {7'd0, err_unprimed}, 8'(PC));
    tick;
    chk("t2_err_sticky", {7'd0, err_unprimed}, 8'(PC));
    idle(3);
    pulse_rst;
    drive(4'b0001, 2'b00, 2'b00, 1'b0);
    chk("b2b_ready0", {4'd0, req_ready}, 8'd1);
    exp_q.push_back(2'd0);
    tick;
    drive(4'b0001, 2'b01, 2'b01, 1'b0);
    chk("b2b_ready1", {4'd0, req_ready}, 8'd1);
    chk("b2b_mode1_first", {6'd0, pa_mode1}, 8'd0);
    exp_q.push_back(2'd0);
    tick;
    drive(4'b0000, 2'b00, 2'b00, 1'b0);
    chk("b2b_mode1", {6'd0, pa_mode1}, 8'd1);
    chk("b2b_mode2", {6'd0, pa_mode2}, 8'd1);
    chk("b2b_err", {7'd0, err_unprimed}, 8'd0);
    tick;
    idle(2);
    pulse_rst;
    drive(4'b0001, 2'b00, 2'b00, 1'b0);
    exp_q.push_back(2'd0);
    tick;
    drive(4'b0001, 2'b01, 2'b01, 1'b1);
    chk("gap_stall_ready", {4'd0, req_ready}, 8'd0);
    chk("gap_stall_sel", {7'd0, pa_sel_valid}, 8'd0);
    tick;
    drive(4'b0001, 2'b01, 2'b01, 1'b0);
    chk("gap_ready", {4'd0, req_ready}, 8'd1);
    chk("gap_idle_mode1", {6'd0, pa_mode1}, 8'd0);
    exp_q.push_back(2'd0);
    tick;
    drive(4'b0000, 2'b00, 2'b00, 1'b0);
    chk("gap_mode1", {6'd0, pa_mode1}, PC ? 8'd0 : 8'd1);
    chk("gap_mode2", {6'd0, pa_mode2}, PC ? 8'd0 : 8'd1);
    chk("gap_err", {7'd0, err_unprimed}, 8'(PC));
    tick;
    idle(2);
    drive(4'b1111, 2'b00, 2'b00, 1'b0);
    chk("stall_pre_ready", {4'd0, req_ready}, 8'd2);
    exp_q.push_back(2'd1);
    tick;
    for (int s = 0; s < 3; s++) begin
      drive(4'b1111, 2'b00, 2'b00, 1'b1);
      chk("stall_ready", {4'd0, req_ready}, 8'd0);
      chk("stall_busy", {7'd0, busy}, s < 2 ? 8'd1 : 8'd0);
      tick;
    end
    drive(4'b1111, 2'b00, 2'b00, 1'b0);
    chk("stall_post_ready", {4'd0, req_ready}, 8'd4);
    exp_q.push_back(2'd2);
    tick;
    idle(3);
    drive(4'b1111, 2'b00, 2'b00, 1'b0);
    chk("mid_ready", {4'd0, req_ready}, 8'd8);
    tick;
    rst = 1'b1;
    drive(4'b1111, 2'b00, 2'b00, 1'b0);
    tick;
    rst = 1'b0;
    drive(4'b1111, 2'b00, 2'b00, 1'b0);
    chk("post_rst_ready", {4'd0, req_ready}, 8'd1);
    chk("post_rst_out0", {7'd0, out_valid}, 8'd0);
    exp_q.push_back(2'd0);
    tick;
    drive(4'b0000, 2'b00, 2'b00, 1'b0);
    chk("post_rst_out1", {7'd0, out_valid}, 8'd0);
    tick;
    idle(3);
    chk("drain", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
